// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit: shift-add multiply and restoring divide,
// one bit per cycle over WIDTH iterations, with sign handling at accept and finish.
module muldiv_unit #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [2:0]       funct3,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result
);

  localparam int unsigned W  = WIDTH;
  localparam int unsigned CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t          state, state_n;
  logic [CW-1:0]   cnt, cnt_n;
  logic [2*W-1:0]  p, p_n;
  logic [W-1:0]    mb, mb_n;
  logic            neg, neg_n;
  logic [2:0]      op, op_n;
  logic [W-1:0]    result_n;
  logic            busy_n, done_n;

  // Operand decode for the incoming request
  logic            in_div, sa, sb, div_zero, div_ovf;
  logic [W-1:0]    mag_a, mag_b;
  assign in_div   = funct3[2];
  assign sa       = a[W-1] & (in_div ? ~funct3[0] : (funct3[1:0] != 2'b11));
  assign sb       = b[W-1] & (in_div ? ~funct3[0] : ~funct3[1]);
  assign mag_a    = sa ? -a : a;
  assign mag_b    = sb ? -b : b;
  assign div_zero = in_div && (b == '0);
  assign div_ovf  = in_div && !funct3[0] && (a == {1'b1, {(W-1){1'b0}}}) && (b == '1);

  // One iteration step: p holds {acc_hi, multiplier} or {remainder, quotient}
  logic [W:0]      sum, shifted, trial;
  logic [2*W-1:0]  prod;
  logic [W-1:0]    quot, rem;
  assign sum     = {1'b0, p[2*W-1:W]} + {1'b0, (p[0] ? mb : {W{1'b0}})};
  assign shifted = p[2*W-1:W-1];
  assign trial   = shifted - {1'b0, mb};
  assign prod    = neg ? -p : p;
  assign quot    = neg ? -p[W-1:0] : p[W-1:0];
  assign rem     = neg ? -p[2*W-1:W] : p[2*W-1:W];

  always_comb begin
    state_n  = state;
    cnt_n    = cnt;
    p_n      = p;
    mb_n     = mb;
    neg_n    = neg;
    op_n     = op;
    result_n = result;
    busy_n   = 1'b0;
    done_n   = 1'b0;
    case (state)
      IDLE, DONE: begin
        state_n = IDLE;
        if (start) begin
          op_n  = funct3;
          cnt_n = '0;
          if (div_zero) begin
            state_n  = DONE;
            done_n   = 1'b1;
            result_n = funct3[1] ? a : {W{1'b1}};
          end else if (div_ovf) begin
            state_n  = DONE;
            done_n   = 1'b1;
            result_n = funct3[1] ? {W{1'b0}} : a;
          end else begin
            state_n = CALC;
            busy_n  = 1'b1;
            if (in_div) begin
              p_n   = {{W{1'b0}}, mag_a};
              mb_n  = mag_b;
              neg_n = funct3[1] ? sa : (sa ^ sb);
            end else begin
              p_n   = {{W{1'b0}}, mag_b};
              mb_n  = mag_a;
              neg_n = sa ^ sb;
            end
          end
        end
      end
      CALC: begin
        if (cnt != CW'(W)) begin
          cnt_n  = cnt + CW'(1);
          busy_n = (cnt != CW'(W - 1));
          if (op[2]) begin
            if (!trial[W]) p_n = {trial[W-1:0], p[W-2:0], 1'b1};
            else           p_n = {p[2*W-2:0], 1'b0};
          end else begin
            p_n = {sum, p[W-1:1]};
          end
        end else begin
          state_n = DONE;
          done_n  = 1'b1;
          if (op[2])                result_n = op[1] ? rem : quot;
          else if (op[1:0] == 2'b00) result_n = prod[W-1:0];
          else                      result_n = prod[2*W-1:W];
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      cnt    <= '0;
      p      <= '0;
      mb     <= '0;
      neg    <= 1'b0;
      op     <= '0;
      result <= '0;
      busy   <= 1'b0;
      done   <= 1'b0;
    end else begin
      state  <= state_n;
      cnt    <= cnt_n;
      p      <= p_n;
      mb     <= mb_n;
      neg    <= neg_n;
      op     <= op_n;
      result <= result_n;
      busy   <= busy_n;
      done   <= done_n;
    end
  end

endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit: directed cases plus randomized ops
// compared against a plain-arithmetic reference model.
module tb_muldiv_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [2:0]  funct3;
  logic [31:0] a, b;
  logic        busy, done;
  logic [31:0] result;

  int errors = 0;
  int checks = 0;
  logic [31:0] prev_exp;

  muldiv_unit #(.WIDTH(32)) dut (
    .clk(clk), .rst(rst), .start(start), .funct3(funct3),
    .a(a), .b(b), .busy(busy), .done(done), .result(result)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] ref_model(input logic [2:0] f, input logic [31:0] x, input logic [31:0] y);
    logic [63:0] ex, ey, pr;
    int sx, sy;
    bit ovf;
    sx  = x;
    sy  = y;
    ovf = (x == 32'h8000_0000) && (y == 32'hFFFF_FFFF);
    ex  = {{32{(f != 3'd3) && x[31]}}, x};
    ey  = {{32{(f == 3'd0 || f == 3'd1) && y[31]}}, y};
    pr  = ex * ey;
    case (f)
      3'd0:    return pr[31:0];
      3'd1, 3'd2, 3'd3: return pr[63:32];
      3'd4:    return (y == 0) ? 32'hFFFF_FFFF : ovf ? x : 32'(sx / sy);
      3'd5:    return (y == 0) ? 32'hFFFF_FFFF : x / y;
      3'd6:    return (y == 0) ? x : ovf ? 32'd0 : 32'(sx % sy);
      default: return (y == 0) ? x : x % y;
    endcase
  endfunction

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 5))
      0:       return 32'd0;
      1:       return 32'hFFFF_FFFF;
      2:       return 32'h8000_0000;
      3:       return 32'($urandom_range(0, 15));
      default: return $urandom;
    endcase
  endfunction

  // Issue one op and follow it to done; chain=1 issues from inside a done cycle
  task automatic do_op(input string tag, input logic [2:0] f, input logic [31:0] x,
                       input logic [31:0] y, input logic [31:0] exp,
                       input bit chain, input int poke);
    int k, busy_cnt, overlap, held_bad;
    bit special;
    special = f[2] && (y == 0 || (!f[0] && x == 32'h8000_0000 && y == 32'hFFFF_FFFF));
    if (!chain) @(negedge clk);
    start = 1'b1; funct3 = f; a = x; b = y;
    @(posedge clk); #1;
    start = 1'b0; a = $urandom; b = $urandom; funct3 = 3'($urandom);
    k = 0; busy_cnt = 0; overlap = 0; held_bad = 0;
    while (!done && k < 200) begin
      if (busy) busy_cnt++;
      if (result !== prev_exp) held_bad++;
      if (k == poke) begin
        start = 1'b1; a = $urandom; b = $urandom; funct3 = 3'($urandom);
      end else if (k == poke + 1) begin
        start = 1'b0;
      end
      @(posedge clk); #1;
      k++;
    end
    if (busy && done) overlap++;
    check({tag, "_latency"}, 32'(k), special ? 32'd0 : 32'd33);
    check({tag, "_busy_cycles"}, 32'(busy_cnt), special ? 32'd0 : 32'd32);
    check({tag, "_busy_done_overlap"}, 32'(overlap), 32'd0);
    check({tag, "_result_held"}, 32'(held_bad), 32'd0);
    check({tag, "_result"}, result, exp);
    prev_exp = exp;
  endtask

  initial begin
    int dcnt;
    logic [2:0]  rf;
    logic [31:0] ra, rb;
    rst = 1'b1; start = 1'b0; funct3 = '0; a = '0; b = '0;
    prev_exp = 32'd0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(posedge clk); #1;
    check("reset_busy", 32'(busy), 32'd0);
    check("reset_done", 32'(done), 32'd0);
    check("reset_result", result, 32'd0);

    do_op("mul_7_m3", 3'd0, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFEB, 1'b0, -5);
    do_op("mulh_min", 3'd1, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 1'b0, -5);
    do_op("mulhu_min", 3'd3, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 1'b0, -5);
    do_op("mulhsu_min", 3'd2, 32'h8000_0000, 32'h8000_0000, 32'hC000_0000, 1'b0, -5);
    do_op("mulhu_max", 3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 1'b0, -5);
    do_op("div_m7_2", 3'd4, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 1'b0, -5);
    do_op("rem_m7_2", 3'd6, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 1'b0, -5);
    do_op("divu_max_2", 3'd5, 32'hFFFF_FFFF, 32'd2, 32'h7FFF_FFFF, 1'b0, -5);
    do_op("remu_100_7", 3'd7, 32'd100, 32'd7, 32'd2, 1'b0, -5);
    do_op("div_by0", 3'd4, 32'd5, 32'd0, 32'hFFFF_FFFF, 1'b0, -5);
    do_op("remu_by0", 3'd7, 32'd5, 32'd0, 32'd5, 1'b0, -5);
    do_op("div_ovf", 3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1'b0, -5);
    do_op("rem_ovf", 3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 1'b0, -5);
    do_op("start_in_calc", 3'd0, 32'd1234, 32'd5678, 32'd7006652, 1'b0, 10);
    do_op("b2b_mul", 3'd0, 32'd3, 32'd4, 32'd12, 1'b0, -5);
    do_op("b2b_divu", 3'd5, 32'd12, 32'd5, 32'd2, 1'b1, -5);

    // Reset in the middle of a calculation discards the op
    @(negedge clk);
    start = 1'b1; funct3 = 3'd1; a = 32'd99; b = 32'd77;
    @(posedge clk); #1 start = 1'b0;
    repeat (10) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    check("midrst_busy", 32'(busy), 32'd0);
    check("midrst_done", 32'(done), 32'd0);
    check("midrst_result", result, 32'd0);
    dcnt = 0;
    repeat (40) begin
      @(posedge clk); #1;
      if (done || busy) dcnt++;
    end
    check("midrst_no_done", 32'(dcnt), 32'd0);
    prev_exp = 32'd0;

    for (int i = 0; i < 200; i++) begin
      rf = 3'($urandom);
      ra = pick();
      rb = pick();
      do_op("rand", rf, ra, rb, ref_model(rf, ra, rb), 1'(i % 3 == 1), -5);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/muldiv_unit.md
# muldiv_unit

Iterative RV32M multiply/divide unit in the execute stage. It runs beside the ALU and takes the same register-file operands. Its result goes to the same writeback mux as `alu_result`. While `busy` is high, the core holds PC and the instruction in execute, and retires the instruction on `done`. It handles all eight M-extension ops with shared shift-add / restoring-division datapaths over WIDTH iterations.

## Interface
- `WIDTH`, default 32: operand and result width. Must be even and ≥ 4.
- `clk`  in  1  clock. All state updates on rising edge.
- `rst`  in  1  reset. Synchronous, active-high.
- `start`  in  1  request pulse. Sampled only in IDLE or DONE.
- `funct3`  in  3  op select. 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
- `a`  in  WIDTH  rs1 operand. Captured with `start`.
- `b`  in  WIDTH  rs2 operand. Captured with `start`.
- `busy`  out  1  high while computing. Core stall request.
- `done`  out  1  one-cycle pulse; `result` valid in this cycle.
- `result`  out  WIDTH  final value. Held until the next accepted `start` or `rst`.

## Operation
- **States:** IDLE, CALC, DONE.
- **Accept:** `start` high in IDLE or DONE captures `funct3`, `a`, `b` and goes to CALC.
  - Exception: divide-by-zero or signed overflow goes to DONE directly.
  - `start` in CALC is ignored; the captured op is unaffected.
- **Sign pre-processing:**
  - Signed operands are converted to magnitude, with result sign flags recorded.
  - MULH: both operands signed. MULHSU: `a` signed, `b` unsigned. MULHU, DIVU, REMU: both unsigned.
  - DIV: quotient sign = sign(a) XOR sign(b). REM: remainder sign = sign(a).
- **Multiply:** WIDTH iterations of shift-add into a 2·WIDTH accumulator, then sign fixup by two's-complement negate of the full 2·WIDTH product. MUL returns the low half; MULH, MULHSU and MULHU return the high half.
- **Divide:** WIDTH iterations of restoring division, one quotient bit per cycle MSB-first, then sign fixup of quotient or remainder.
- **Special cases** (resolved at accept, no iterations):
  - `b` == 0: DIV/DIVU return all ones; REM/REMU return `a`.
  - DIV with `a` = 100…0 and `b` = all ones: result 100…0. REM for the same operands: result 0.
- **CALC → DONE:** after the iteration counter reaches WIDTH. `result` is registered on entry to DONE.
- **DONE:** lasts exactly one cycle, then goes to IDLE unless a new `start` is accepted, which goes to CALC or DONE per the rules above.
- **Operands:** `a` and `b` may change after the accept cycle with no effect.

## Timing
- **Reset:** `rst` high at an edge forces IDLE, `busy`=0, `done`=0, `result`=0, counter=0, and clears internal registers. This holds regardless of state, including mid-CALC, where the in-flight op is discarded and no `done` is produced.
- **Normal latency:** `start` sampled at edge 0.
  - `busy`=1 from after edge 0 through edge WIDTH (WIDTH cycles).
  - `done`=1 and `result` valid in the cycle after edge WIDTH+1. Latency is WIDTH+1 edges.
- **Special-case latency:** `done`=1 in the cycle after edge 0. `busy` stays 0.
- **Stall window:** `busy` and `done` are never high together.
- **Back-to-back:** the core may assert `start` in the `done` cycle; the next op begins with no idle bubble.
- **Outputs:** all outputs are registered; no combinational path from inputs to outputs.

## Test plan
- **Reset defaults and idle accept:** `rst` for 2 cycles, then idle → `busy`=0, `done`=0, `result`=0. Then MUL a=7, b=−3 → `done` after 33 edges, `result`=0xFFFFFFEB, and `busy` high exactly 32 cycles.
- **MULH variants:** a=0x80000000, b=0x80000000.
  - MULH → 0x40000000.
  - MULHU → 0x40000000.
  - MULHSU (a signed, b unsigned) → 0xC0000000.
  - MULHU a=b=0xFFFFFFFF → 0xFFFFFFFE.
- **Division signs:**
  - DIV −7/2 → 0xFFFFFFFD.
  - REM −7/2 → 0xFFFFFFFF.
  - DIVU 0xFFFFFFFF/2 → 0x7FFFFFFF.
  - REMU 100/7 → 2.
- **Special cases:**
  - DIV 5/0 → 0xFFFFFFFF.
  - REMU 5/0 → 5.
  - DIV 0x80000000/0xFFFFFFFF → 0x80000000.
  - REM same operands → 0.
  - Each gives `done` one cycle after accept with `busy` never high.
- **Mid-operation events:**
  - `start` pulsed at cycle 10 of CALC with different operands → ignored; the original result is returned.
  - `rst` at cycle 10 of CALC → IDLE next cycle, no `done`, `result`=0.
- **Back-to-back:** `start` asserted in the `done` cycle (MUL 3·4 then DIVU 12/5) → 12, then 2, with no idle cycle between ops. `result` holds 12 until the second `done`.
